// File: rtl/icache_assoc_mem.sv
// icache_assoc_mem
//   N-way set-associative instruction cache storage array with tree pseudo-LRU
//   replacement, invalid-way-first allocation, duplicate-tag suppression on
//   fill and a sequential whole-cache flush engine.
//
// Parameters
//   NUM_SETS  number of sets (power of two, >= 2)
//   NUM_WAYS  associativity (1, 2, 4 or 8)
//   LINE_W    line width in bits (one line = 8 bytes of PC space)
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   rd_en                lookup qualifier (gates PLRU update and statistics)
//   rd_pc_reg            lookup PC: index = [IDX_W+2:3], tag = [63:IDX_W+3]
//   rd_data, rd_valid    combinational hit line / hit flag (0 / 0 on miss)
//   wr_en, wr_pc_reg,
//   wr_data              line fill
//   flush_req            start full invalidation
//   flush_busy           sweep in progress
//   flush_done           registered one-cycle pulse after the sweep
//   hit_count,
//   miss_count           saturating lookup statistics (ICACHE_STATS_EN only)
//
// Build option
//   ICACHE_STATS_EN  when defined, adds the hit_count/miss_count ports and
//                    their counters.
module icache_assoc_mem #(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned LINE_W   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [63:0]       rd_pc_reg,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [63:0]       wr_pc_reg,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 64 - IDX_W - 3;
  localparam int unsigned LVLS   = $clog2(NUM_WAYS);
  localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? LVLS : 1;
  localparam int unsigned PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [PLRU_W-1:0]   plru_q  [NUM_SETS];

  logic [0:0]       state_q;
  logic [IDX_W-1:0] ctr_q;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit;
  logic [WAY_W-1:0] rd_way;
  logic             wr_hit, wr_inv;
  logic [WAY_W-1:0] wr_hit_way, wr_inv_way, wr_way;
  logic             fill_go;
  logic             unused_offsets;

  // Tree bits are stored heap-style: node n (root = 1) lives at bit n-1,
  // its children are 2n and 2n+1, and leaves NUM_WAYS..2*NUM_WAYS-1 map to ways.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < LVLS; l++) begin
      node = 2 * node + 32'(bits[node-1]);
    end
    return WAY_W'(node - NUM_WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] r;
    int unsigned       node;
    logic              dir;
    r    = bits;
    node = 1;
    for (int unsigned l = 0; l < LVLS; l++) begin
      dir       = way[LVLS-1-l];
      r[node-1] = ~dir;
      node      = 2 * node + 32'(dir);
    end
    return r;
  endfunction

  assign rd_idx         = rd_pc_reg[IDX_W+2:3];
  assign rd_tag         = rd_pc_reg[63:IDX_W+3];
  assign wr_idx         = wr_pc_reg[IDX_W+2:3];
  assign wr_tag         = wr_pc_reg[63:IDX_W+3];
  assign unused_offsets = ^{rd_pc_reg[2:0], wr_pc_reg[2:0]};

  assign flush_busy = (state_q == ST_FLUSH);
  assign fill_go    = wr_en && (state_q == ST_IDLE) && !flush_req;

  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!rd_hit && valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit = 1'b1;
        rd_way = WAY_W'(w);
      end
    end
  end

  assign rd_valid = rd_hit && !flush_busy;
  assign rd_data  = rd_valid ? data_q[rd_idx][rd_way] : '0;

  // Fill target priority: existing copy of the tag, then lowest invalid way,
  // then the PLRU victim.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    wr_inv     = 1'b0;
    wr_inv_way = '0;
    wr_way     = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!wr_hit && valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_hit     = 1'b1;
        wr_hit_way = WAY_W'(w);
      end
      if (!wr_inv && !valid_q[wr_idx][w]) begin
        wr_inv     = 1'b1;
        wr_inv_way = WAY_W'(w);
      end
    end
    if (wr_hit)      wr_way = wr_hit_way;
    else if (wr_inv) wr_way = wr_inv_way;
    else             wr_way = plru_victim(plru_q[wr_idx]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      flush_done <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      flush_done <= 1'b0;
      if (state_q == ST_FLUSH) begin
        valid_q[ctr_q] <= '0;
        plru_q[ctr_q]  <= '0;
        ctr_q          <= ctr_q + 1'b1;
        if (ctr_q == IDX_W'(NUM_SETS - 1)) begin
          state_q    <= ST_IDLE;
          flush_done <= 1'b1;
        end
      end else if (flush_req) begin
        state_q <= ST_FLUSH;
        ctr_q   <= '0;
      end else begin
        // A fill to the same set overrides the read's recency update.
        if (rd_en && rd_hit && !(wr_en && (wr_idx == rd_idx))) begin
          plru_q[rd_idx] <= plru_touch(plru_q[rd_idx], rd_way);
        end
        if (wr_en) begin
          valid_q[wr_idx][wr_way] <= 1'b1;
          plru_q[wr_idx]          <= plru_touch(plru_q[wr_idx], wr_way);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill_go) begin
      tag_q[wr_idx][wr_way]  <= wr_tag;
      data_q[wr_idx][wr_way] <= wr_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rd_en && !flush_busy) begin
      if (rd_valid) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule
